// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atm_pkg
// Description : Shared constants, key codes and debounce FSM encoding for the
//               ATM keypad (PIN digits and amount entry).
// Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

   localparam int MONTO_W = 32;
   localparam int DIG_W   = 4;

   localparam logic [DIG_W-1:0] TECLA_BORRAR = 4'hA;
   localparam logic [DIG_W-1:0] TECLA_ENTER  = 4'hB;

   typedef enum logic [2:0] {
      REPOSO      = 3'd0,
      REBOTE_PRES = 3'd1,
      ACEPTAR     = 3'd2,
      ESPERA_SOLT = 3'd3,
      REBOTE_SOLT = 3'd4
   } estado_t;

   // Codes 0..9 are numeric keys; everything above is a function or unused key.
   function automatic logic es_digito(input logic [DIG_W-1:0] tecla);
      return (tecla <= 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/antirrebote_tecla.sv
`default_nettype none
// ============================================================================
// Module      : antirrebote_tecla
// Description : Two-flop synchronizer plus press/release debounce FSM. Emits a
//               single-cycle event per physical press with the latched code.
// Revision    : 1.0 - initial release
// ============================================================================
module antirrebote_tecla
   import atm_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIG_W-1:0] i_tecla,
   input  logic             i_tecla_activa,
   input  logic             i_habilitar,
   input  logic             i_abortar,
   output logic             o_evento,
   output logic [DIG_W-1:0] o_codigo
);

   localparam int c_cnt_w  = $clog2(DEBOUNCE_CYC + 1);
   localparam int c_cnt_w1 = c_cnt_w + 1;
   localparam logic [c_cnt_w:0] c_deb = c_cnt_w1'(DEBOUNCE_CYC);

   logic             r_act_s1, r_act_s2;
   logic [DIG_W-1:0] r_tecla_s1, r_tecla_s2;
   estado_t          r_estado, w_estado_sig;
   logic [c_cnt_w-1:0] r_cnt, w_cnt_sig;
   logic [c_cnt_w:0]   w_cnt_inc;
   logic [DIG_W-1:0] r_codigo, w_codigo_sig;
   logic [1:0]       r_valido;
   logic             r_armado;

   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
   assign o_codigo  = r_codigo;

   // Synchronize the raw asynchronous key level and code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_s1   <= 1'b0;
         r_act_s2   <= 1'b0;
         r_tecla_s1 <= '0;
         r_tecla_s2 <= '0;
      end else begin
         r_act_s1   <= i_tecla_activa;
         r_act_s2   <= r_act_s1;
         r_tecla_s1 <= i_tecla;
         r_tecla_s2 <= r_tecla_s1;
      end
   end

   // FSM state, counter, latched code; arm only once the key is seen released
   // after the synchronizer has refilled, so a press held across reset is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= REPOSO;
         r_cnt    <= '0;
         r_codigo <= '0;
         r_valido <= 2'b00;
         r_armado <= 1'b0;
      end else begin
         r_estado <= w_estado_sig;
         r_cnt    <= w_cnt_sig;
         r_codigo <= w_codigo_sig;
         r_valido <= {r_valido[0], 1'b1};
         if (r_valido[1] && !r_act_s2) r_armado <= 1'b1;
      end
   end

   // Next-state logic; the event fires only in ACEPTAR and is killed by abort.
   always_comb begin
      w_estado_sig = r_estado;
      w_cnt_sig    = r_cnt;
      w_codigo_sig = r_codigo;
      o_evento     = 1'b0;
      unique case (r_estado)
         REPOSO: begin
            if (r_act_s2 && i_habilitar && r_armado) begin
               w_estado_sig = REBOTE_PRES;
               w_cnt_sig    = c_cnt_w'(1);
               w_codigo_sig = r_tecla_s2;
            end
         end
         REBOTE_PRES: begin
            if (i_abortar) begin
               w_estado_sig = r_act_s2 ? ESPERA_SOLT : REPOSO;
               w_cnt_sig    = '0;
            end else if (!r_act_s2 || (r_tecla_s2 != r_codigo)) begin
               w_estado_sig = REPOSO;
               w_cnt_sig    = '0;
            end else if (w_cnt_inc >= c_deb) begin
               w_estado_sig = ACEPTAR;
               w_cnt_sig    = '0;
            end else begin
               w_cnt_sig    = w_cnt_inc[c_cnt_w-1:0];
            end
         end
         ACEPTAR: begin
            o_evento     = !i_abortar;
            w_estado_sig = (i_abortar && !r_act_s2) ? REPOSO : ESPERA_SOLT;
         end
         ESPERA_SOLT: begin
            if (!r_act_s2) begin
               w_estado_sig = REBOTE_SOLT;
               w_cnt_sig    = c_cnt_w'(1);
            end
         end
         REBOTE_SOLT: begin
            if (r_act_s2) begin
               w_estado_sig = ESPERA_SOLT;
               w_cnt_sig    = '0;
            end else if (w_cnt_inc >= c_deb) begin
               w_estado_sig = REPOSO;
               w_cnt_sig    = '0;
            end else begin
               w_cnt_sig    = w_cnt_inc[c_cnt_w-1:0];
            end
         end
         default: begin
            w_estado_sig = REPOSO;
            w_cnt_sig    = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/teclado_atm.sv
`default_nettype none
// ============================================================================
// Module      : teclado_atm
// Description : ATM keypad front end. Debounced keys feed either the PIN digit
//               strobe (Modo=0) or a decimal amount accumulator (Modo=1).
// Revision    : 1.0 - initial release
// ============================================================================
module teclado_atm
   import atm_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int MAX_DIG      = 9
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               Tarjeta_Recibida,
   input  logic               Modo,
   input  logic [DIG_W-1:0]   Tecla,
   input  logic               Tecla_Activa,
   output logic [DIG_W-1:0]   Digito,
   output logic               Digito_STB,
   output logic [MONTO_W-1:0] Monto,
   output logic               Monto_STB,
   output logic [DIG_W-1:0]   Cuenta_Dig
);

   localparam logic [DIG_W-1:0] c_max_dig = DIG_W'(MAX_DIG);

   logic             r_modo_prev;
   logic             w_abortar;
   logic             w_evento;
   logic [DIG_W-1:0] w_codigo;

   // A mode switch or card removal cancels any press in flight and the amount.
   assign w_abortar = (Modo != r_modo_prev) || !Tarjeta_Recibida;

   antirrebote_tecla #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_antirrebote (
      .clk            (CLK),
      .rst_n          (RESET_N),
      .i_tecla        (Tecla),
      .i_tecla_activa (Tecla_Activa),
      .i_habilitar    (Tarjeta_Recibida),
      .i_abortar      (w_abortar),
      .o_evento       (w_evento),
      .o_codigo       (w_codigo)
   );

   // PIN/amount datapath; the cycle after an amount strobe clears the amount.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_modo_prev <= 1'b0;
         Digito      <= '0;
         Digito_STB  <= 1'b0;
         Monto       <= '0;
         Monto_STB   <= 1'b0;
         Cuenta_Dig  <= '0;
      end else begin
         r_modo_prev <= Modo;
         Digito_STB  <= 1'b0;
         Monto_STB   <= 1'b0;
         if (w_abortar || Monto_STB) begin
            Monto      <= '0;
            Cuenta_Dig <= '0;
         end else if (w_evento) begin
            if (!Modo) begin
               if (es_digito(w_codigo)) begin
                  Digito     <= w_codigo;
                  Digito_STB <= 1'b1;
               end
            end else if (es_digito(w_codigo)) begin
               if (Cuenta_Dig < c_max_dig) begin
                  Monto      <= Monto * MONTO_W'(10) + MONTO_W'(w_codigo);
                  Cuenta_Dig <= Cuenta_Dig + DIG_W'(1);
               end
            end else if (w_codigo == TECLA_BORRAR) begin
               Monto      <= '0;
               Cuenta_Dig <= '0;
            end else if ((w_codigo == TECLA_ENTER) && (Cuenta_Dig != '0)) begin
               Monto_STB <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_teclado_atm.sv
`default_nettype none
// ============================================================================
// Module      : tb_teclado_atm
// Description : Self-checking bench for teclado_atm with a behavioural model
//               of PIN digits and decimal amount entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_teclado_atm;

   localparam int MAX_DIG = 9;

   logic        CLK;
   logic        RESET_N;
   logic        Tarjeta_Recibida;
   logic        Modo;
   logic [3:0]  Tecla;
   logic        Tecla_Activa;
   logic [3:0]  Digito;
   logic        Digito_STB;
   logic [31:0] Monto;
   logic        Monto_STB;
   logic [3:0]  Cuenta_Dig;

   int checks   = 0;
   int failures = 0;

   // observation of one stimulus window; index k = state just after edge k
   logic [31:0] obs_monto [0:127];
   logic [3:0]  obs_cnt   [0:127];
   int          n_obs, n_dstb, dstb_idx, n_mstb, mstb_idx;
   int          both_cnt = 0;
   logic [3:0]  dstb_val;
   logic [31:0] mstb_val;

   // reference model state
   logic [3:0]  exp_digito;
   longint      exp_monto;
   int          exp_cnt;

   teclado_atm #(
      .DEBOUNCE_CYC (4),
      .MAX_DIG      (MAX_DIG)
   ) dut (
      .CLK              (CLK),
      .RESET_N          (RESET_N),
      .Tarjeta_Recibida (Tarjeta_Recibida),
      .Modo             (Modo),
      .Tecla            (Tecla),
      .Tecla_Activa     (Tecla_Activa),
      .Digito           (Digito),
      .Digito_STB       (Digito_STB),
      .Monto            (Monto),
      .Monto_STB        (Monto_STB),
      .Cuenta_Dig       (Cuenta_Dig)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_obs();
      n_obs = 0; n_dstb = 0; dstb_idx = -1; dstb_val = '0;
      n_mstb = 0; mstb_idx = -1; mstb_val = '0;
   endtask

   task automatic drive(input logic act, input int n);
      Tecla_Activa = act;
      for (int i = 0; i < n; i++) begin
         tick();
         if (n_obs < 127) n_obs++;
         obs_monto[n_obs] = Monto;
         obs_cnt[n_obs]   = Cuenta_Dig;
         if (Digito_STB) begin n_dstb++; dstb_idx = n_obs; dstb_val = Digito; end
         if (Monto_STB)  begin n_mstb++; mstb_idx = n_obs; mstb_val = Monto;  end
         if (Digito_STB && Monto_STB) both_cnt++;
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold, input int gap);
      clear_obs();
      Tecla = code;
      drive(1'b1, hold);
      drive(1'b0, gap);
   endtask

   // amount rules: digit appends when room, Borrar clears, Enter emits if any digits
   task automatic model_amount(input logic [3:0] c, output bit stb, output logic [31:0] v);
      stb = 1'b0; v = '0;
      if (c <= 4'd9) begin
         if (exp_cnt < MAX_DIG) begin
            exp_monto = exp_monto * 10 + longint'(c);
            exp_cnt++;
         end
      end else if (c == 4'hA) begin
         exp_monto = 0; exp_cnt = 0;
      end else if (c == 4'hB && exp_cnt > 0) begin
         stb = 1'b1; v = exp_monto[31:0];
         exp_monto = 0; exp_cnt = 0;
      end
   endtask

   task automatic set_modo(input logic m);
      Modo = m;
      clear_obs();
      drive(1'b0, 3);
      exp_monto = 0; exp_cnt = 0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b1; Tarjeta_Recibida = 1'b1; Modo = 1'b0;
      Tecla = 4'($urandom_range(0, 15)); Tecla_Activa = 1'b1;
      #3 RESET_N = 1'b0;
      #1;
      checks++;
      if ({Digito, Digito_STB, Monto, Monto_STB, Cuenta_Dig} !== '0) begin
         failures++;
         $display("FAIL reset_async: got Digito=%0h STB=%b Monto=%0d MSTB=%b Cuenta=%0d required all 0",
                  Digito, Digito_STB, Monto, Monto_STB, Cuenta_Dig);
      end
      clear_obs();
      drive(1'b1, 4);
      checks++;
      if ({Digito, Digito_STB, Monto, Monto_STB, Cuenta_Dig} !== '0 || n_dstb != 0) begin
         failures++;
         $display("FAIL reset_held: got Digito=%0h Monto=%0d Cuenta=%0d strobes=%0d required all 0",
                  Digito, Monto, Cuenta_Dig, n_dstb);
      end
      Tecla_Activa = 1'b0;
      RESET_N = 1'b1;
      drive(1'b0, 6);
      exp_digito = 4'd0; exp_monto = 0; exp_cnt = 0;
   endtask

   task automatic test_pin_fixed();
      logic [3:0] codes [4] = '{4'd8, 4'd5, 4'd5, 4'd1};
      for (int i = 0; i < 4; i++) begin
         press(codes[i], 6, 8);
         exp_digito = codes[i];
         checks++;
         if (n_dstb != 1 || dstb_idx != 7 || dstb_val !== codes[i]) begin
            failures++;
            $display("FAIL pin_fixed[%0d]: got %0d strobes at cycle %0d digit %0h required 1 at cycle 7 digit %0h",
                     i, n_dstb, dstb_idx, dstb_val, codes[i]);
         end
         checks++;
         if (n_mstb != 0) begin
            failures++;
            $display("FAIL pin_fixed_no_monto[%0d]: got %0d Monto_STB required 0", i, n_mstb);
         end
      end
   endtask

   task automatic test_pin_random();
      for (int i = 0; i < 10; i++) begin
         logic [3:0] c;
         int exp_n;
         c = 4'($urandom_range(0, 15));
         press(c, $urandom_range(5, 12), $urandom_range(6, 12));
         exp_n = (c <= 4'd9) ? 1 : 0;
         if (exp_n == 1) exp_digito = c;
         checks++;
         if (n_dstb != exp_n || (exp_n == 1 && (dstb_idx != 7 || dstb_val !== c))) begin
            failures++;
            $display("FAIL pin_random[%0d] key %0h: got %0d strobes cycle %0d digit %0h required %0d strobes cycle 7",
                     i, c, n_dstb, dstb_idx, dstb_val, exp_n);
         end
         checks++;
         if (Digito !== exp_digito) begin
            failures++;
            $display("FAIL pin_hold[%0d]: got Digito=%0h required %0h", i, Digito, exp_digito);
         end
      end
   endtask

   task automatic test_bounce();
      clear_obs();
      Tecla = 4'd5;
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b1, 10);
      drive(1'b0, 10);
      exp_digito = 4'd5;
      checks++;
      if (n_dstb != 1 || dstb_val !== 4'd5) begin
         failures++;
         $display("FAIL bounce: got %0d strobes digit %0h required 1 strobe digit 5", n_dstb, dstb_val);
      end
   endtask

   task automatic test_amount_fixed();
      logic [3:0] codes [5] = '{4'd4, 4'd3, 4'd6, 4'd8, 4'd0};
      bit stb;
      logic [31:0] v;
      set_modo(1'b1);
      for (int i = 0; i < 5; i++) begin
         press(codes[i], 6, 8);
         model_amount(codes[i], stb, v);
         checks++;
         if (Monto !== exp_monto[31:0] || Cuenta_Dig !== 4'(exp_cnt) || n_dstb != 0) begin
            failures++;
            $display("FAIL amount_fixed[%0d]: got Monto=%0d Cuenta=%0d dstb=%0d required Monto=%0d Cuenta=%0d dstb=0",
                     i, Monto, Cuenta_Dig, n_dstb, exp_monto, exp_cnt);
         end
      end
      press(4'hB, 6, 8);
      model_amount(4'hB, stb, v);
      checks++;
      if (n_mstb != 1 || mstb_idx != 7 || mstb_val !== 32'h0000_AAA0 || obs_monto[6] !== 32'h0000_AAA0) begin
         failures++;
         $display("FAIL amount_enter: got %0d strobes cycle %0d Monto=%0d required 1 strobe cycle 7 Monto=43680",
                  n_mstb, mstb_idx, mstb_val);
      end
      checks++;
      if (obs_monto[8] !== 32'd0 || obs_cnt[8] !== 4'd0) begin
         failures++;
         $display("FAIL amount_clear: got Monto=%0d Cuenta=%0d after strobe required 0 0", obs_monto[8], obs_cnt[8]);
      end
   endtask

   task automatic test_amount_max();
      bit stb;
      logic [31:0] v;
      press(4'hA, 6, 8);
      model_amount(4'hA, stb, v);
      for (int i = 0; i < 10; i++) begin
         press(4'd9, 5, 7);
         model_amount(4'd9, stb, v);
      end
      checks++;
      if (Cuenta_Dig !== 4'd9 || Monto !== 32'd999999999) begin
         failures++;
         $display("FAIL amount_max: got Monto=%0d Cuenta=%0d required 999999999 9", Monto, Cuenta_Dig);
      end
      press(4'hB, 6, 8);
      model_amount(4'hB, stb, v);
      checks++;
      if (n_mstb != 1 || mstb_val !== 32'd999999999) begin
         failures++;
         $display("FAIL amount_max_enter: got %0d strobes Monto=%0d required 1 strobe 999999999", n_mstb, mstb_val);
      end
   endtask

   task automatic test_amount_random();
      bit stb;
      logic [31:0] v;
      for (int i = 0; i < 16; i++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom_range(0, 15));
         press(c, $urandom_range(5, 12), $urandom_range(6, 12));
         model_amount(c, stb, v);
         checks++;
         if (Monto !== exp_monto[31:0] || Cuenta_Dig !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL amount_random[%0d] key %0h: got Monto=%0d Cuenta=%0d required Monto=%0d Cuenta=%0d",
                     i, c, Monto, Cuenta_Dig, exp_monto, exp_cnt);
         end
         checks++;
         if (n_mstb != int'(stb) || (stb && (mstb_idx != 7 || mstb_val !== v)) || n_dstb != 0) begin
            failures++;
            $display("FAIL amount_random_stb[%0d] key %0h: got %0d strobes Monto=%0d required %0d strobes Monto=%0d",
                     i, c, n_mstb, mstb_val, stb, v);
         end
      end
   endtask

   task automatic test_abort();
      bit stb;
      logic [31:0] v;
      press(4'hA, 6, 8); model_amount(4'hA, stb, v);
      press(4'd1, 6, 8); model_amount(4'd1, stb, v);
      press(4'd2, 6, 8); model_amount(4'd2, stb, v);
      checks++;
      if (Monto !== 32'd12) begin
         failures++;
         $display("FAIL abort_setup: got Monto=%0d required 12", Monto);
      end
      clear_obs();
      Tecla = 4'd3;
      drive(1'b1, 4);
      Tarjeta_Recibida = 1'b0;
      drive(1'b1, 6);
      drive(1'b0, 10);
      Tarjeta_Recibida = 1'b1;
      drive(1'b0, 3);
      exp_monto = 0; exp_cnt = 0;
      checks++;
      if (n_dstb != 0 || n_mstb != 0) begin
         failures++;
         $display("FAIL abort_no_strobe: got dstb=%0d mstb=%0d required 0 0", n_dstb, n_mstb);
      end
      checks++;
      if (obs_monto[4] !== 32'd12 || obs_monto[5] !== 32'd0 || obs_cnt[5] !== 4'd0) begin
         failures++;
         $display("FAIL abort_clear: got Monto=%0d then %0d Cuenta=%0d required 12 then 0 and 0",
                  obs_monto[4], obs_monto[5], obs_cnt[5]);
      end
      press(4'd7, 6, 8); model_amount(4'd7, stb, v);
      checks++;
      if (Monto !== exp_monto[31:0] || Cuenta_Dig !== 4'(exp_cnt)) begin
         failures++;
         $display("FAIL abort_resume: got Monto=%0d Cuenta=%0d required %0d %0d", Monto, Cuenta_Dig, exp_monto, exp_cnt);
      end
   endtask

   task automatic test_reset_mid_press();
      set_modo(1'b0);
      clear_obs();
      Tecla = 4'd7;
      drive(1'b1, 9);
      checks++;
      if (n_dstb != 1 || dstb_val !== 4'd7) begin
         failures++;
         $display("FAIL rst_press_first: got %0d strobes digit %0h required 1 digit 7", n_dstb, dstb_val);
      end
      #3 RESET_N = 1'b0;
      #1;
      exp_digito = 4'd0;
      checks++;
      if ({Digito, Digito_STB, Monto, Monto_STB, Cuenta_Dig} !== '0) begin
         failures++;
         $display("FAIL rst_press_async: got Digito=%0h STB=%b Monto=%0d Cuenta=%0d required all 0",
                  Digito, Digito_STB, Monto, Cuenta_Dig);
      end
      drive(1'b1, 2);
      RESET_N = 1'b1;
      clear_obs();
      drive(1'b1, 15);
      drive(1'b0, 8);
      checks++;
      if (n_dstb != 0 || Digito !== 4'd0) begin
         failures++;
         $display("FAIL rst_press_discard: got %0d strobes Digito=%0h required 0 strobes Digito=0", n_dstb, Digito);
      end
      press(4'd7, 6, 8);
      checks++;
      if (n_dstb != 1 || dstb_idx != 7 || dstb_val !== 4'd7) begin
         failures++;
         $display("FAIL rst_press_again: got %0d strobes cycle %0d digit %0h required 1 cycle 7 digit 7",
                  n_dstb, dstb_idx, dstb_val);
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_cnt != 0) begin
         failures++;
         $display("FAIL strobe_exclusive: got %0d cycles with both strobes required 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_pin_fixed();
      test_pin_random();
      test_bounce();
      test_amount_fixed();
      test_amount_max();
      test_amount_random();
      test_abort();
      test_reset_mid_press();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
